// File: rtl/p_core_dma_mc_if.sv
// p_core_dma_mc_if: single-beat AXI master/slave bundle for the DMA engine
interface p_core_dma_mc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [3:0]          aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_qos;
  logic [5:0]          aw_atop;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [3:0]          ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_qos;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;
  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_atop, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );
  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_atop, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/p_core_dma_mc.sv
// p_core_dma_mc: multi-channel round-robin single-beat AXI DMA; P_CORE_DMA_MC_IRQ_EN adds irq_o and CTRL.IEN
module p_core_dma_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              cfg_req_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic [DATA_W-1:0] cfg_rdata_o,
  output logic              cfg_rvalid_o,
`ifdef P_CORE_DMA_MC_IRQ_EN
  output logic [NUM_CH-1:0] irq_o,
`endif
  p_core_dma_mc_if.master   axi
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  typedef enum logic [2:0] {IDLE, ARB, RD_A, RD_D, WR, WR_B} state_t;
  state_t            state;
  logic [ADDR_W-1:0] src [8];
  logic [ADDR_W-1:0] dst [8];
  logic [ADDR_W-1:0] wsrc [8];
  logic [ADDR_W-1:0] wdst [8];
  logic [LEN_W-1:0]  len [8];
  logic [LEN_W-1:0]  wlen [8];
  logic [7:0]        busy, done, err, ien;
  logic [2:0]        cur, last, nxt;
  logic              found;
  logic [DATA_W-1:0] rd_val;
  logic              unused_in;
  logic [2:0]        ch;
  logic [1:0]        rs;
  logic              ch_ok, wr_en;
  assign ch        = cfg_addr_i[7:5];
  assign rs        = cfg_addr_i[4:3];
  assign ch_ok     = 32'(ch) < NUM_CH;
  assign wr_en     = cfg_req_i & cfg_we_i & ch_ok;
  assign unused_in = ^{cfg_wdata_i, cfg_addr_i[2:0]};
`ifdef P_CORE_DMA_MC_IRQ_EN
  assign irq_o = done[NUM_CH-1:0] & ien[NUM_CH-1:0];
`else
  assign ien = '0;
`endif
  assign axi.ar_id    = '0;
  assign axi.ar_len   = '0;
  assign axi.ar_size  = 3'(OFF);
  assign axi.ar_burst = 2'b01;
  assign axi.ar_cache = '0;
  assign axi.ar_prot  = '0;
  assign axi.ar_qos   = '0;
  assign axi.aw_id    = '0;
  assign axi.aw_len   = '0;
  assign axi.aw_size  = 3'(OFF);
  assign axi.aw_burst = 2'b01;
  assign axi.aw_cache = '0;
  assign axi.aw_prot  = '0;
  assign axi.aw_qos   = '0;
  assign axi.aw_atop  = '0;
  assign axi.w_strb   = '1;
  assign axi.w_last   = 1'b1;
  always_comb begin
    rd_val = '0;
    if (ch_ok)
      rd_val = rs == 2'd0 ? DATA_W'(src[ch]) :
               rs == 2'd1 ? DATA_W'(dst[ch]) :
               rs == 2'd2 ? DATA_W'(len[ch]) :
               DATA_W'({ien[ch], err[ch], done[ch], busy[ch]});
  end
  // Descending scan so the channel closest after the last served one wins
  always_comb begin
    nxt   = last;
    found = 1'b0;
    for (int i = NUM_CH; i >= 1; i--)
      if (busy[(int'(last) + i) % NUM_CH]) begin
        nxt   = 3'((int'(last) + i) % NUM_CH);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state        <= IDLE;
      for (int c = 0; c < 8; c++) begin
        src[c]  <= '0;
        dst[c]  <= '0;
        wsrc[c] <= '0;
        wdst[c] <= '0;
        len[c]  <= '0;
        wlen[c] <= '0;
      end
      busy         <= '0;
      done         <= '0;
      err          <= '0;
`ifdef P_CORE_DMA_MC_IRQ_EN
      ien          <= '0;
`endif
      cur          <= '0;
      last         <= 3'(NUM_CH - 1);
      cfg_rdata_o  <= '0;
      cfg_rvalid_o <= 1'b0;
      axi.ar_addr  <= '0;
      axi.ar_valid <= 1'b0;
      axi.r_ready  <= 1'b0;
      axi.aw_addr  <= '0;
      axi.aw_valid <= 1'b0;
      axi.w_data   <= '0;
      axi.w_valid  <= 1'b0;
      axi.b_ready  <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i & ~cfg_we_i;
      cfg_rdata_o  <= (cfg_req_i & ~cfg_we_i) ? rd_val : '0;
      if (wr_en && !busy[ch] && rs == 2'd0) src[ch] <= {cfg_wdata_i[ADDR_W-1:OFF], {OFF{1'b0}}};
      if (wr_en && !busy[ch] && rs == 2'd1) dst[ch] <= {cfg_wdata_i[ADDR_W-1:OFF], {OFF{1'b0}}};
      if (wr_en && !busy[ch] && rs == 2'd2) len[ch] <= cfg_wdata_i[LEN_W-1:0];
      if (wr_en && rs == 2'd3) begin
        if (cfg_wdata_i[2]) begin
          done[ch] <= 1'b0;
          err[ch]  <= 1'b0;
        end
`ifdef P_CORE_DMA_MC_IRQ_EN
        ien[ch] <= cfg_wdata_i[3];
`endif
        if (cfg_wdata_i[0] && !busy[ch] && len[ch] == '0) done[ch] <= 1'b1;
        if (cfg_wdata_i[0] && !busy[ch] && len[ch] != '0) begin
          busy[ch] <= 1'b1;
          done[ch] <= 1'b0;
          err[ch]  <= 1'b0;
          wsrc[ch] <= src[ch];
          wdst[ch] <= dst[ch];
          wlen[ch] <= len[ch];
        end
      end
      // FSM updates to the served channel come last so they win over register writes
      case (state)
        IDLE: if (|busy) state <= ARB;
        ARB: begin
          state <= found ? RD_A : IDLE;
          if (found) begin
            cur          <= nxt;
            last         <= nxt;
            axi.ar_addr  <= wsrc[nxt];
            axi.ar_valid <= 1'b1;
          end
        end
        RD_A: if (axi.ar_ready) begin
          axi.ar_valid <= 1'b0;
          axi.r_ready  <= 1'b1;
          state        <= RD_D;
        end
        RD_D: if (axi.r_valid) begin
          axi.r_ready <= 1'b0;
          if (axi.r_resp != 2'b00) begin
            err[cur]  <= 1'b1;
            busy[cur] <= 1'b0;
            state     <= ARB;
          end else begin
            axi.w_data   <= axi.r_data;
            axi.aw_addr  <= wdst[cur];
            axi.aw_valid <= 1'b1;
            axi.w_valid  <= 1'b1;
            state        <= WR;
          end
        end
        WR: begin
          if (axi.aw_ready) axi.aw_valid <= 1'b0;
          if (axi.w_ready) axi.w_valid <= 1'b0;
          if ((!axi.aw_valid || axi.aw_ready) && (!axi.w_valid || axi.w_ready)) begin
            axi.b_ready <= 1'b1;
            state       <= WR_B;
          end
        end
        WR_B: if (axi.b_valid) begin
          axi.b_ready <= 1'b0;
          state       <= ARB;
          if (axi.b_resp != 2'b00) begin
            err[cur]  <= 1'b1;
            busy[cur] <= 1'b0;
          end else begin
            wsrc[cur] <= wsrc[cur] + ADDR_W'(BYTES);
            wdst[cur] <= wdst[cur] + ADDR_W'(BYTES);
            wlen[cur] <= wlen[cur] - 1'b1;
            if (wlen[cur] == LEN_W'(1)) begin
              busy[cur] <= 1'b0;
              done[cur] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p_core_dma_mc.sv
// tb_p_core_dma_mc: register vectors plus AXI scoreboard scenarios for p_core_dma_mc
module tb_p_core_dma_mc;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
`ifdef P_CORE_DMA_MC_IRQ_EN
  localparam logic [63:0] IEN_RB = 64'h8;
`else
  localparam logic [63:0] IEN_RB = 64'h0;
`endif
  typedef struct {
    bit          we;
    int          c;
    int          r;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        cfg_req = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [63:0] cfg_wdata = '0;
  logic [63:0] cfg_rdata;
  logic        cfg_rvalid;
`ifdef P_CORE_DMA_MC_IRQ_EN
  logic [NUM_CH-1:0] irq;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ar_rdy = 1'b1;
  int aw_dly = 0;
  bit r_hold = 1'b0;
  int err_at = -1;
  int rd_cnt, aw_cnt;
  bit aw_got, w_got;
  bit any_valid = 1'b0;
  bit saw_indep = 1'b0;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [63:0] exp_w[$];
  int          ar_t[$];
  vec_t        tv[16];
  logic [63:0] rv;

  p_core_dma_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  p_core_dma_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(16)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_ni),
    .cfg_req_i   (cfg_req),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .cfg_rvalid_o(cfg_rvalid),
`ifdef P_CORE_DMA_MC_IRQ_EN
    .irq_o       (irq),
`endif
    .axi         (axi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] data_of(logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave: 1-cycle R and B responses, optional AW stall, optional read error
  assign axi.ar_ready = ar_rdy;
  assign axi.w_ready  = 1'b1;
  assign axi.aw_ready = aw_cnt >= aw_dly;
  always @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      axi.r_valid <= 1'b0;
      axi.r_data  <= '0;
      axi.r_resp  <= '0;
      axi.b_valid <= 1'b0;
      axi.b_resp  <= '0;
      aw_cnt      <= 0;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      rd_cnt      <= 0;
    end else begin
      if (axi.r_valid && axi.r_ready) axi.r_valid <= 1'b0;
      if (axi.ar_valid && axi.ar_ready) begin
        rd_cnt <= rd_cnt + 1;
        if (!r_hold) begin
          axi.r_valid <= 1'b1;
          axi.r_data  <= data_of(axi.ar_addr);
          axi.r_resp  <= (rd_cnt == err_at) ? 2'b10 : 2'b00;
        end
      end
      aw_cnt <= (axi.aw_valid && !axi.aw_ready) ? aw_cnt + 1 : 0;
      if (axi.b_valid && axi.b_ready) axi.b_valid <= 1'b0;
      if ((aw_got || (axi.aw_valid && axi.aw_ready)) && (w_got || (axi.w_valid && axi.w_ready))) begin
        axi.b_valid <= 1'b1;
        aw_got      <= 1'b0;
        w_got       <= 1'b0;
      end else begin
        aw_got <= aw_got || (axi.aw_valid && axi.aw_ready);
        w_got  <= w_got || (axi.w_valid && axi.w_ready);
      end
    end
  end

  // Monitor: handshakes are sampled half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (arst_ni) begin
      if (axi.ar_valid || axi.aw_valid || axi.w_valid) any_valid = 1'b1;
      if (axi.aw_valid && !axi.w_valid) saw_indep = 1'b1;
      if (axi.ar_valid && axi.ar_ready) begin
        ar_t.push_back(cyc);
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(axi.ar_addr), 64'hDEAD_BEEF_0000_0000);
        else chk("ar_addr_size_len", {axi.ar_addr, axi.ar_size, axi.ar_len}, {exp_ar.pop_front(), 3'd3, 8'd0});
      end
      if (axi.aw_valid && axi.aw_ready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(axi.aw_addr), 64'hDEAD_BEEF_0000_0000);
        else chk("aw_addr_size_burst", {axi.aw_addr, axi.aw_size, axi.aw_burst}, {exp_aw.pop_front(), 3'd3, 2'b01});
      end
      if (axi.w_valid && axi.w_ready) begin
        chk("w_strb_last", {axi.w_strb, axi.w_last}, {8'hFF, 1'b1});
        if (exp_w.size() == 0) chk("w_unexpected", axi.w_data, 64'hDEAD_BEEF_0000_0000);
        else chk("w_data", axi.w_data, exp_w.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    arst_ni = 1'b0;
    ar_rdy  = 1'b1;
    aw_dly  = 0;
    r_hold  = 1'b0;
    err_at  = -1;
    exp_ar.delete();
    exp_aw.delete();
    exp_w.delete();
    ar_t.delete();
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;
  endtask

  task automatic wr(int c, int r, logic [63:0] d);
    @(negedge clk);
    cfg_req   = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = {3'(c), 2'(r), 3'b000};
    cfg_wdata = d;
    @(negedge clk);
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic rd(int c, int r, output logic [63:0] d);
    @(negedge clk);
    cfg_req  = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = {3'(c), 2'(r), 3'b000};
    @(negedge clk);
    cfg_req = 1'b0;
    if (!cfg_rvalid) chk("rvalid", 64'(cfg_rvalid), 64'd1);
    d = cfg_rdata;
  endtask

  task automatic wait_idle(int c, string nm);
    logic [63:0] s;
    s = 64'd1;
    for (int i = 0; i < 300 && s[0]; i++) rd(c, 3, s);
    chk(nm, 64'(s[0]), 64'd0);
  endtask

  task automatic push_beat(logic [31:0] s, logic [31:0] d);
    exp_ar.push_back(s);
    exp_aw.push_back(d);
    exp_w.push_back(data_of(s));
  endtask

  task automatic chk_empty(string nm);
    chk(nm, 64'(exp_ar.size() + exp_aw.size() + exp_w.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0, 0, 3, 64'h0, 64'h0};
    tv[1]  = '{0, 0, 0, 64'h0, 64'h0};
    tv[2]  = '{1, 0, 0, 64'h1007, 64'h0};
    tv[3]  = '{0, 0, 0, 64'h0, 64'h1000};
    tv[4]  = '{1, 1, 1, 64'hFFFF_FFFF_1234_567F, 64'h0};
    tv[5]  = '{0, 1, 1, 64'h0, 64'h1234_5678};
    tv[6]  = '{1, 3, 2, 64'h5, 64'h0};
    tv[7]  = '{0, 3, 2, 64'h0, 64'h5};
    tv[8]  = '{1, 5, 0, 64'hABC0, 64'h0};
    tv[9]  = '{0, 5, 0, 64'h0, 64'h0};
    tv[10] = '{1, 2, 3, 64'h8, 64'h0};
    tv[11] = '{0, 2, 3, 64'h0, IEN_RB};
    tv[12] = '{1, 2, 3, 64'h4, 64'h0};
    tv[13] = '{0, 2, 3, 64'h0, 64'h0};
    tv[14] = '{1, 3, 2, 64'h1_0007, 64'h0};
    tv[15] = '{0, 3, 2, 64'h0, 64'h7};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready, cfg_rvalid, |cfg_rdata}, 64'd0);
    arst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tv[i].we) wr(tv[i].c, tv[i].r, tv[i].d);
      else begin
        rd(tv[i].c, tv[i].r, rv);
        chk($sformatf("vec%0d", i), rv, tv[i].exp);
      end
    end

    // Four-beat copy on channel 0
    do_reset();
    for (int i = 0; i < 4; i++) push_beat(32'h1000 + 32'(8 * i), 32'h2000 + 32'(8 * i));
    wr(0, 0, 64'h1000);
    wr(0, 1, 64'h2000);
    wr(0, 2, 64'h4);
    wr(0, 3, 64'h1);
    wait_idle(0, "a_idle");
    rd(0, 3, rv);
    chk("a_stat", rv, 64'h2);
    chk_empty("a_queue");
    chk("a_nbeats", 64'(ar_t.size()), 64'd4);
    if (ar_t.size() >= 2) chk("a_beat_cycles", 64'(ar_t[1] - ar_t[0]), 64'd5);

    // Round-robin between channels 0 and 2
    do_reset();
    push_beat(32'h100, 32'h300);
    push_beat(32'h500, 32'h700);
    push_beat(32'h108, 32'h308);
    push_beat(32'h508, 32'h708);
    wr(0, 0, 64'h100);
    wr(0, 1, 64'h300);
    wr(0, 2, 64'h2);
    wr(2, 0, 64'h500);
    wr(2, 1, 64'h700);
    wr(2, 2, 64'h2);
    wr(0, 3, 64'h1);
    wr(2, 3, 64'h1);
    wait_idle(0, "b_idle0");
    wait_idle(2, "b_idle2");
    rd(0, 3, rv);
    chk("b_stat0", rv, 64'h2);
    rd(2, 3, rv);
    chk("b_stat2", rv, 64'h2);
    chk_empty("b_queue");

    // Read error on the second beat of channel 1
    do_reset();
    err_at = 1;
    push_beat(32'h4000, 32'h5000);
    exp_ar.push_back(32'h4008);
    wr(1, 0, 64'h4000);
    wr(1, 1, 64'h5000);
    wr(1, 2, 64'h3);
    wr(1, 3, 64'h1);
    wait_idle(1, "c_idle");
    rd(1, 3, rv);
    chk("c_stat_err", rv, 64'h4);
    chk_empty("c_queue");
    wr(1, 3, 64'h4);
    rd(1, 3, rv);
    chk("c_stat_clr", rv, 64'h0);

    // Zero-length start and writes while busy
    do_reset();
    any_valid = 1'b0;
    wr(3, 2, 64'h0);
    wr(3, 3, 64'h1);
    rd(3, 3, rv);
    chk("d_len0_done", rv, 64'h2);
    repeat (10) @(negedge clk);
    chk("d_no_valid", 64'(any_valid), 64'd0);
    ar_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(32'h600 + 32'(8 * i), 32'h900 + 32'(8 * i));
    wr(3, 0, 64'h600);
    wr(3, 1, 64'h900);
    wr(3, 2, 64'h3);
    wr(3, 3, 64'h1);
    wr(3, 2, 64'h9);
    wr(3, 0, 64'h7770);
    rd(3, 2, rv);
    chk("d_len_locked", rv, 64'h3);
    rd(3, 0, rv);
    chk("d_src_locked", rv, 64'h600);
    rd(3, 3, rv);
    chk("d_busy", rv, 64'h1);
    ar_rdy = 1'b1;
    wait_idle(3, "d_idle");
    rd(3, 3, rv);
    chk("d_stat", rv, 64'h2);
    chk_empty("d_queue");

    // Address wrap and AW held back behind W
    do_reset();
    aw_dly    = 3;
    saw_indep = 1'b0;
    push_beat(32'hFFFF_FFF8, 32'h8000);
    push_beat(32'h0000_0000, 32'h8008);
    wr(0, 0, 64'hFFFF_FFF8);
    wr(0, 1, 64'h8000);
    wr(0, 2, 64'h2);
    wr(0, 3, 64'h1);
    wait_idle(0, "e_idle");
    rd(0, 3, rv);
    chk("e_stat", rv, 64'h2);
    chk("e_aw_w_indep", 64'(saw_indep), 64'd1);
    chk_empty("e_queue");

    // Asynchronous reset while waiting for read data
    do_reset();
    r_hold = 1'b1;
    exp_ar.push_back(32'h100);
    wr(0, 0, 64'h100);
    wr(0, 1, 64'h200);
    wr(0, 2, 64'h1);
    wr(0, 3, 64'h1);
    for (int i = 0; i < 50 && !axi.r_ready; i++) @(negedge clk);
    chk("f_in_rd_d", 64'(axi.r_ready), 64'd1);
    #2;
    arst_ni = 1'b0;
    #1;
    chk("f_valids_low", {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}, 64'd0);
    do_reset();
    rd(0, 3, rv);
    chk("f_stat", rv, 64'h0);
    rd(0, 0, rv);
    chk("f_src", rv, 64'h0);
    repeat (10) @(negedge clk);
    chk("f_no_resume", 64'(axi.ar_valid), 64'd0);

`ifdef P_CORE_DMA_MC_IRQ_EN
    do_reset();
    wr(0, 2, 64'h0);
    chk("g_irq_reset", 64'(irq), 64'd0);
    wr(0, 3, 64'h9);
    chk("g_irq_set", 64'(irq), 64'd1);
    wr(0, 3, 64'hC);
    chk("g_irq_clr", 64'(irq), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
